// File: rtl/tv80_regfile_banked.sv
// -----------------------------------------------------------------------------
// tv80_regfile_banked
// Banked register-pair file for the TV80 datapath. NBANKS banks of NPAIRS
// register pairs (high/low byte, DW bits each), three combinational read ports
// and one write port. Supports EXX (active-bank advance), EX DE,HL (per-bank
// pair-swap flag), in-place 2*DW-bit increment/decrement and optional
// same-cycle write-through bypass on the read ports.
//
// Ports:
//   clk, reset            clock; synchronous active-high clear
//   cen                   clock enable, 0 freezes all state (reads stay live)
//   addr_a/addr_b/addr_c  logical pair for write+read A, read B, read C
//   di_h/di_l, we_h/we_l  write data and byte enables for pair addr_a
//   inc_a/dec_a           in-place increment/decrement of pair addr_a
//   exx, ex_dehl          bank advance / toggle DE-HL swap of active bank
//   do_ah..do_cl          read data, ports A/B/C
//   bank, swap            active bank index, per-bank swap flags
// -----------------------------------------------------------------------------
module tv80_regfile_banked #(
    parameter int DW     = 8,
    parameter int NPAIRS = 4,
    parameter int NBANKS = 2,
    parameter int DE_IDX = 1,
    parameter int HL_IDX = 2,
    parameter int BYPASS = 1,
    localparam int PAW   = (NPAIRS > 1) ? $clog2(NPAIRS) : 1,
    localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cen,
    input  logic [PAW-1:0]    addr_a,
    input  logic [PAW-1:0]    addr_b,
    input  logic [PAW-1:0]    addr_c,
    input  logic [DW-1:0]     di_h,
    input  logic [DW-1:0]     di_l,
    input  logic              we_h,
    input  logic              we_l,
    input  logic              inc_a,
    input  logic              dec_a,
    input  logic              exx,
    input  logic              ex_dehl,
    output logic [DW-1:0]     do_ah,
    output logic [DW-1:0]     do_al,
    output logic [DW-1:0]     do_bh,
    output logic [DW-1:0]     do_bl,
    output logic [DW-1:0]     do_ch,
    output logic [DW-1:0]     do_cl,
    output logic [BW-1:0]     bank,
    output logic [NBANKS-1:0] swap
);

    // Remapping only applies when both swap targets are real pairs.
    localparam bit             MAP_EN = (DE_IDX < NPAIRS) && (HL_IDX < NPAIRS);
    localparam logic [PAW-1:0] DE_A   = PAW'(DE_IDX);
    localparam logic [PAW-1:0] HL_A   = PAW'(HL_IDX);
    localparam logic [PAW:0]   NP     = (PAW+1)'(NPAIRS);
    localparam logic [2*DW-1:0] ONE   = (2*DW)'(1);

    logic [DW-1:0]     mem_h_r [NBANKS][NPAIRS];
    logic [DW-1:0]     mem_l_r [NBANKS][NPAIRS];
    logic [BW-1:0]     bank_r;
    logic [NBANKS-1:0] swap_r;
    logic [BW-1:0]     next_bank_s;

    logic [PAW-1:0]    laddr_s [3];
    logic [PAW-1:0]    paddr_s [3];
    logic [DW-1:0]     rd_h_s  [3];
    logic [DW-1:0]     rd_l_s  [3];
    logic [2*DW-1:0]   cur_a_s;
    logic              a_valid_s;

    // Logical-to-physical pair mapping under the active bank's swap flag.
    function automatic logic [PAW-1:0] map_pair(input logic [PAW-1:0] a, input logic sw);
        logic [PAW-1:0] m;
        m = a;
        if (MAP_EN && sw) begin
            if (a == DE_A) begin
                m = HL_A;
            end else if (a == HL_A) begin
                m = DE_A;
            end else begin
                m = a;
            end
        end else begin
            m = a;
        end
        return m;
    endfunction

    assign laddr_s[0] = addr_a;
    assign laddr_s[1] = addr_b;
    assign laddr_s[2] = addr_c;

    // Combinational reads through the current mapping, with optional bypass
    // keyed on the logical address (same mapping applies to both sides).
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            paddr_s[p] = map_pair(laddr_s[p], swap_r[bank_r]);
            rd_h_s[p]  = {DW{1'b0}};
            rd_l_s[p]  = {DW{1'b0}};
            if ({1'b0, paddr_s[p]} < NP) begin
                rd_h_s[p] = mem_h_r[bank_r][paddr_s[p]];
                rd_l_s[p] = mem_l_r[bank_r][paddr_s[p]];
            end else begin
                rd_h_s[p] = {DW{1'b0}};
                rd_l_s[p] = {DW{1'b0}};
            end
            if ((BYPASS != 0) && (laddr_s[p] == addr_a) && we_h) begin
                rd_h_s[p] = di_h;
            end else begin
                rd_h_s[p] = rd_h_s[p];
            end
            if ((BYPASS != 0) && (laddr_s[p] == addr_a) && we_l) begin
                rd_l_s[p] = di_l;
            end else begin
                rd_l_s[p] = rd_l_s[p];
            end
        end
    end

    // Current contents of pair A (pre-swap mapping) for increment/decrement.
    always_comb begin
        a_valid_s = ({1'b0, paddr_s[0]} < NP);
        cur_a_s   = {rd_h_s[0], rd_l_s[0]};
        if (a_valid_s) begin
            cur_a_s = {mem_h_r[bank_r][paddr_s[0]], mem_l_r[bank_r][paddr_s[0]]};
        end else begin
            cur_a_s = {(2*DW){1'b0}};
        end
    end

    // Bank index that EXX advances to, wrapping at NBANKS.
    always_comb begin
        if (bank_r == BW'(NBANKS - 1)) begin
            next_bank_s = {BW{1'b0}};
        end else begin
            next_bank_s = bank_r + BW'(1);
        end
    end

    // State update: reset, then byte write over inc/dec, then bank/swap changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int p = 0; p < NPAIRS; p++) begin
                    mem_h_r[b][p] <= {DW{1'b0}};
                    mem_l_r[b][p] <= {DW{1'b0}};
                end
            end
            bank_r <= {BW{1'b0}};
            swap_r <= {NBANKS{1'b0}};
        end else if (cen) begin
            if (a_valid_s) begin
                if (we_h || we_l) begin
                    if (we_h) begin
                        mem_h_r[bank_r][paddr_s[0]] <= di_h;
                    end
                    if (we_l) begin
                        mem_l_r[bank_r][paddr_s[0]] <= di_l;
                    end
                end else if (inc_a ^ dec_a) begin
                    {mem_h_r[bank_r][paddr_s[0]], mem_l_r[bank_r][paddr_s[0]]} <=
                        inc_a ? (cur_a_s + ONE) : (cur_a_s - ONE);
                end
            end
            // Swap toggles on the pre-EXX bank.
            if (ex_dehl) begin
                swap_r[bank_r] <= ~swap_r[bank_r];
            end
            if (exx) begin
                bank_r <= next_bank_s;
            end
        end
    end

    assign do_ah = rd_h_s[0];
    assign do_al = rd_l_s[0];
    assign do_bh = rd_h_s[1];
    assign do_bl = rd_l_s[1];
    assign do_ch = rd_h_s[2];
    assign do_cl = rd_l_s[2];
    assign bank  = bank_r;
    assign swap  = swap_r;

endmodule

// File: tb/tb_tv80_regfile_banked.sv
// Directed vector bench for tv80_regfile_banked: a bypassing instance and a
// non-bypassing instance share all inputs; each vector's expected read values
// describe the state left by earlier vectors plus same-cycle bypass.
module tb_tv80_regfile_banked;

    logic       clk = 1'b0;
    logic       reset, cen, we_h, we_l, inc_a, dec_a, exx, ex_dehl;
    logic [1:0] addr_a, addr_b, addr_c;
    logic [7:0] di_h, di_l;
    logic [7:0] do_ah, do_al, do_bh, do_bl, do_ch, do_cl;
    logic [0:0] bank;
    logic [1:0] swap;
    logic [7:0] n_ah, n_al, n_bh, n_bl, n_ch, n_cl;
    logic [0:0] n_bank;
    logic [1:0] n_swap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tv80_regfile_banked dut (
        .clk(clk), .reset(reset), .cen(cen),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .di_h(di_h), .di_l(di_l), .we_h(we_h), .we_l(we_l),
        .inc_a(inc_a), .dec_a(dec_a), .exx(exx), .ex_dehl(ex_dehl),
        .do_ah(do_ah), .do_al(do_al), .do_bh(do_bh), .do_bl(do_bl),
        .do_ch(do_ch), .do_cl(do_cl), .bank(bank), .swap(swap)
    );

    tv80_regfile_banked #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .cen(cen),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .di_h(di_h), .di_l(di_l), .we_h(we_h), .we_l(we_l),
        .inc_a(inc_a), .dec_a(dec_a), .exx(exx), .ex_dehl(ex_dehl),
        .do_ah(n_ah), .do_al(n_al), .do_bh(n_bh), .do_bl(n_bl),
        .do_ch(n_ch), .do_cl(n_cl), .bank(n_bank), .swap(n_swap)
    );

    // ctl = {reset, cen, we_h, we_l, inc_a, dec_a, exx, ex_dehl}
    typedef struct {
        logic [7:0]  ctl;
        logic [1:0]  a, b, c;
        logic [15:0] di;
        logic [15:0] ea, eb, ec;
        logic [0:0]  ebank;
        logic [1:0]  eswap;
        logic [15:0] enbb;
    } vec_t;

    vec_t vecs [34];

    task automatic check(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {reset, cen, we_h, we_l, inc_a, dec_a, exx, ex_dehl} = v.ctl;
        addr_a = v.a;
        addr_b = v.b;
        addr_c = v.c;
        {di_h, di_l} = v.di;
    endtask

    initial begin
        //            ctl           a     b     c     di        A         B         C      bank  swap   nb B
        vecs[0]  = '{8'b01000000, 2'd0, 2'd1, 2'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 16'h0000};
        vecs[1]  = '{8'b01110000, 2'd0, 2'd0, 2'd1, 16'h1234, 16'h1234, 16'h1234, 16'h0000, 1'b0, 2'b00, 16'h0000};
        vecs[2]  = '{8'b11000000, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 1'b0, 2'b00, 16'h1234};
        vecs[3]  = '{8'b01000000, 2'd0, 2'd0, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 16'h0000};
        vecs[4]  = '{8'b01110000, 2'd2, 2'd2, 2'd0, 16'hABCD, 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 2'b00, 16'h0000};
        vecs[5]  = '{8'b01000000, 2'd2, 2'd0, 2'd2, 16'h0000, 16'hABCD, 16'h0000, 16'hABCD, 1'b0, 2'b00, 16'h0000};
        vecs[6]  = '{8'b01110000, 2'd2, 2'd2, 2'd1, 16'h1111, 16'h1111, 16'h1111, 16'h0000, 1'b0, 2'b00, 16'hABCD};
        vecs[7]  = '{8'b01000010, 2'd2, 2'd2, 2'd2, 16'h0000, 16'h1111, 16'h1111, 16'h1111, 1'b0, 2'b00, 16'h1111};
        vecs[8]  = '{8'b01110000, 2'd2, 2'd2, 2'd0, 16'h2222, 16'h2222, 16'h2222, 16'h0000, 1'b1, 2'b00, 16'h0000};
        vecs[9]  = '{8'b01000010, 2'd2, 2'd2, 2'd2, 16'h0000, 16'h2222, 16'h2222, 16'h2222, 1'b1, 2'b00, 16'h2222};
        vecs[10] = '{8'b01000000, 2'd2, 2'd2, 2'd2, 16'h0000, 16'h1111, 16'h1111, 16'h1111, 1'b0, 2'b00, 16'h1111};
        vecs[11] = '{8'b01110000, 2'd1, 2'd1, 2'd2, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h1111, 1'b0, 2'b00, 16'h0000};
        vecs[12] = '{8'b01110000, 2'd2, 2'd1, 2'd2, 16'h5555, 16'h5555, 16'hAAAA, 16'h5555, 1'b0, 2'b00, 16'hAAAA};
        vecs[13] = '{8'b01000001, 2'd1, 2'd2, 2'd0, 16'h0000, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 2'b00, 16'h5555};
        vecs[14] = '{8'b01000000, 2'd1, 2'd2, 2'd0, 16'h0000, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, 2'b01, 16'hAAAA};
        vecs[15] = '{8'b01000010, 2'd1, 2'd2, 2'd2, 16'h0000, 16'h5555, 16'hAAAA, 16'hAAAA, 1'b0, 2'b01, 16'hAAAA};
        vecs[16] = '{8'b01000000, 2'd1, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 1'b1, 2'b01, 16'h2222};
        vecs[17] = '{8'b01000010, 2'd1, 2'd2, 2'd3, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 1'b1, 2'b01, 16'h2222};
        vecs[18] = '{8'b01000000, 2'd1, 2'd2, 2'd0, 16'h0000, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, 2'b01, 16'hAAAA};
        vecs[19] = '{8'b01110000, 2'd3, 2'd3, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 2'b01, 16'h0000};
        vecs[20] = '{8'b01001000, 2'd3, 2'd3, 2'd0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 2'b01, 16'hFFFF};
        vecs[21] = '{8'b01000100, 2'd3, 2'd3, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b01, 16'h0000};
        vecs[22] = '{8'b01001100, 2'd3, 2'd3, 2'd0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 2'b01, 16'hFFFF};
        vecs[23] = '{8'b01011000, 2'd3, 2'd3, 2'd3, 16'h7742, 16'hFF42, 16'hFF42, 16'hFF42, 1'b0, 2'b01, 16'hFFFF};
        vecs[24] = '{8'b01000000, 2'd3, 2'd3, 2'd1, 16'h0000, 16'hFF42, 16'hFF42, 16'h5555, 1'b0, 2'b01, 16'hFF42};
        vecs[25] = '{8'b01000001, 2'd1, 2'd2, 2'd0, 16'h0000, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, 2'b01, 16'hAAAA};
        vecs[26] = '{8'b00110011, 2'd1, 2'd1, 2'd2, 16'h9988, 16'h9988, 16'h9988, 16'h5555, 1'b0, 2'b00, 16'hAAAA};
        vecs[27] = '{8'b01000000, 2'd1, 2'd1, 2'd2, 16'h0000, 16'hAAAA, 16'hAAAA, 16'h5555, 1'b0, 2'b00, 16'hAAAA};
        vecs[28] = '{8'b01110011, 2'd1, 2'd2, 2'd1, 16'h9988, 16'h9988, 16'h5555, 16'h9988, 1'b0, 2'b00, 16'h5555};
        vecs[29] = '{8'b01000000, 2'd1, 2'd2, 2'd3, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 1'b1, 2'b01, 16'h2222};
        vecs[30] = '{8'b01000010, 2'd1, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 1'b1, 2'b01, 16'h2222};
        vecs[31] = '{8'b01000000, 2'd1, 2'd2, 2'd0, 16'h0000, 16'h5555, 16'h9988, 16'h0000, 1'b0, 2'b01, 16'h9988};
        vecs[32] = '{8'b10110011, 2'd1, 2'd2, 2'd0, 16'h1234, 16'h1234, 16'h9988, 16'h0000, 1'b0, 2'b01, 16'h9988};
        vecs[33] = '{8'b01000000, 2'd1, 2'd2, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 16'h0000};

        // Hand-written reset sequence: hold reset, then sweep every address.
        {reset, cen, we_h, we_l, inc_a, dec_a, exx, ex_dehl} = 8'b11000000;
        addr_a = 2'd0; addr_b = 2'd0; addr_c = 2'd0;
        di_h = 8'h00; di_l = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_a = 2'(i);
            addr_b = 2'(3 - i);
            addr_c = 2'(i);
            @(negedge clk);
            check("rst_a", i, {do_ah, do_al}, 16'h0000);
            check("rst_b", i, {do_bh, do_bl}, 16'h0000);
            check("rst_c", i, {do_ch, do_cl}, 16'h0000);
            check("rst_bank", i, {15'd0, bank}, 16'h0000);
            check("rst_swap", i, {14'd0, swap}, 16'h0000);
            @(posedge clk);
            #1;
        end

        // Table-driven vectors: drive after the edge, compare at the negedge.
        for (int i = 0; i < 34; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check("port_a", i, {do_ah, do_al}, vecs[i].ea);
            check("port_b", i, {do_bh, do_bl}, vecs[i].eb);
            check("port_c", i, {do_ch, do_cl}, vecs[i].ec);
            check("bank", i, {15'd0, bank}, {15'd0, vecs[i].ebank});
            check("swap", i, {14'd0, swap}, {14'd0, vecs[i].eswap});
            check("nobyp_b", i, {n_bh, n_bl}, vecs[i].enbb);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
